// File: rtl/binary_clock_top.sv
// Binary clock top: prescaler, BCD HH:MM counter and a WS2812 4x4 matrix serializer.
// Optional macro TWELVE_HOUR_EN switches the hour counter to 12-hour style (01..12).
module binary_clock_top #(
    parameter int          CLK_HZ      = 12000000,
    parameter int          SEC_PER_MIN = 60,
    parameter int          T0H_CYC     = 4,
    parameter int          T1H_CYC     = 8,
    parameter int          TBIT_CYC    = 15,
    parameter int          TRST_CYC    = 600,
    parameter logic [23:0] ON_COLOR    = 24'h001000
) (
    input  logic clk,
    input  logic rst,
    output logic led1,
    output logic led2,
    output logic led3,
    output logic led4,
    output logic ws_data
);

    localparam int PW = $clog2(CLK_HZ + 1);
    localparam int SW = $clog2(SEC_PER_MIN + 1);
    localparam int GW = $clog2(TRST_CYC + 1);
    localparam int BW = $clog2(TBIT_CYC + 1);

`ifdef TWELVE_HOUR_EN
    localparam logic [3:0] H1_RST = 4'd1;
    localparam logic [3:0] H0_RST = 4'd2;
`else
    localparam logic [3:0] H1_RST = 4'd0;
    localparam logic [3:0] H0_RST = 4'd0;
`endif

    typedef enum logic {IDLE_GAP, SEND} ser_state_t;

    logic [PW-1:0] presc_reg;
    logic [SW-1:0] sec_reg;
    logic [3:0]    h1_reg, h0_reg, m1_reg, m0_reg;
    logic          sec_tick, min_tick;

    always_comb begin
        sec_tick = (presc_reg == PW'(CLK_HZ - 1));
        min_tick = sec_tick && (sec_reg == SW'(SEC_PER_MIN - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg <= '0;
            sec_reg   <= '0;
        end else begin
            presc_reg <= sec_tick ? '0 : presc_reg + 1'b1;
            if (sec_tick)
                sec_reg <= min_tick ? '0 : sec_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h1_reg <= H1_RST;
            h0_reg <= H0_RST;
            m1_reg <= 4'd0;
            m0_reg <= 4'd0;
        end else if (min_tick) begin
            if (m0_reg == 4'd9) begin
                m0_reg <= 4'd0;
                if (m1_reg == 4'd5) begin
                    m1_reg <= 4'd0;
`ifdef TWELVE_HOUR_EN
                    if (h1_reg == 4'd1 && h0_reg == 4'd2) begin
                        h1_reg <= 4'd0;
                        h0_reg <= 4'd1;
                    end else
`else
                    if (h1_reg == 4'd2 && h0_reg == 4'd3) begin
                        h1_reg <= 4'd0;
                        h0_reg <= 4'd0;
                    end else
`endif
                    if (h0_reg == 4'd9) begin
                        h1_reg <= h1_reg + 4'd1;
                        h0_reg <= 4'd0;
                    end else begin
                        h0_reg <= h0_reg + 4'd1;
                    end
                end else begin
                    m1_reg <= m1_reg + 4'd1;
                end
            end else begin
                m0_reg <= m0_reg + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led1 <= H1_RST[0];
            led2 <= H0_RST[0];
            led3 <= 1'b0;
            led4 <= 1'b0;
        end else begin
            led1 <= h1_reg[0];
            led2 <= h0_reg[0];
            led3 <= m1_reg[0];
            led4 <= m0_reg[0];
        end
    end

    // Pixel p = col*4 + row: column gi holds digit gi (h1, h0, m1, m0), row = digit bit.
    logic [3:0]  digit [4];
    logic [15:0] pix_mask;

    always_comb begin
        digit[0] = h1_reg;
        digit[1] = h0_reg;
        digit[2] = m1_reg;
        digit[3] = m0_reg;
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col
            assign pix_mask[gi*4 +: 4] = digit[gi];
        end
    endgenerate

    ser_state_t    state_reg;
    logic [GW-1:0] gap_reg;
    logic [BW-1:0] bit_cyc_reg;
    logic [3:0]    pix_idx_reg;
    logic [4:0]    sub_idx_reg;
    logic [15:0]   frame_reg;
    logic          cur_bit;
    logic [BW-1:0] high_len;

    always_comb begin
        cur_bit  = frame_reg[pix_idx_reg] & ON_COLOR[5'd23 - sub_idx_reg];
        high_len = cur_bit ? BW'(T1H_CYC) : BW'(T0H_CYC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE_GAP;
            gap_reg     <= '0;
            bit_cyc_reg <= '0;
            pix_idx_reg <= 4'd0;
            sub_idx_reg <= 5'd0;
            frame_reg   <= 16'd0;
            ws_data     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE_GAP: begin
                    ws_data <= 1'b0;
                    if (gap_reg == GW'(TRST_CYC - 1)) begin
                        gap_reg     <= '0;
                        frame_reg   <= pix_mask;
                        bit_cyc_reg <= '0;
                        pix_idx_reg <= 4'd0;
                        sub_idx_reg <= 5'd0;
                        state_reg   <= SEND;
                    end else begin
                        gap_reg <= gap_reg + 1'b1;
                    end
                end
                SEND: begin
                    ws_data <= (bit_cyc_reg < high_len);
                    if (bit_cyc_reg == BW'(TBIT_CYC - 1)) begin
                        bit_cyc_reg <= '0;
                        if (sub_idx_reg == 5'd23) begin
                            sub_idx_reg <= 5'd0;
                            if (pix_idx_reg == 4'd15) begin
                                pix_idx_reg <= 4'd0;
                                state_reg   <= IDLE_GAP;
                            end else begin
                                pix_idx_reg <= pix_idx_reg + 4'd1;
                            end
                        end else begin
                            sub_idx_reg <= sub_idx_reg + 5'd1;
                        end
                    end else begin
                        bit_cyc_reg <= bit_cyc_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE_GAP;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_clock_top.sv
// Scoreboard bench: fast-time instance checks LED digits, slow-time instance decodes WS2812 frames.
module tb_binary_clock_top;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_t = 1'b1;
    logic rst_f = 1'b1;
    logic t_led1, t_led2, t_led3, t_led4, t_ws;
    logic f_led1, f_led2, f_led3, f_led4, f_ws;

    binary_clock_top #(.CLK_HZ(2), .SEC_PER_MIN(2)) dut_t (
        .clk(clk), .rst(rst_t),
        .led1(t_led1), .led2(t_led2), .led3(t_led3), .led4(t_led4),
        .ws_data(t_ws)
    );

    binary_clock_top #(.CLK_HZ(100), .SEC_PER_MIN(4)) dut_f (
        .clk(clk), .rst(rst_f),
        .led1(f_led1), .led2(f_led2), .led3(f_led3), .led4(f_led4),
        .ws_data(f_ws)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         n;
        logic [3:0] leds;
    } led_exp_t;

    led_exp_t    led_q[$];
    logic [23:0] pix_q[$];
    int          gap_q[$];
    int          frames_done = 0;
    bit          done_t = 1'b0;
    bit          done_f = 1'b0;

`ifdef TWELVE_HOUR_EN
    localparam logic [3:0]  RST_LEDS  = 4'b1000;
    localparam logic [15:0] MASK_0001 = 16'h1021;  // 12:01
    localparam logic [15:0] MASK_0017 = 16'h7121;  // 12:17
`else
    localparam logic [3:0]  RST_LEDS  = 4'b0000;
    localparam logic [15:0] MASK_0001 = 16'h1000;  // 00:01
    localparam logic [15:0] MASK_0017 = 16'h7100;  // 00:17
`endif

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic push_led(input int n, input logic [3:0] leds);
        led_exp_t e;
        e.n    = n;
        e.leds = leds;
        led_q.push_back(e);
    endtask

    task automatic push_frame(input logic [15:0] mask);
        gap_q.push_back(600);
        for (int p = 0; p < 16; p++)
            pix_q.push_back(mask[p] ? 24'h001000 : 24'h000000);
    endtask

    // LED stimulus: n = clock edges since reset release, leds = {led1,led2,led3,led4}.
    initial begin : stim_t
`ifdef TWELVE_HOUR_EN
        push_led(0,    4'b1000);
        push_led(4,    4'b1000);
        push_led(5,    4'b1001);
        push_led(41,   4'b1010);
        push_led(237,  4'b1011);
        push_led(241,  4'b0100);
        push_led(2397, 4'b0111);
        push_led(2401, 4'b1000);
        push_led(2877, 4'b1111);
        push_led(2881, 4'b1000);
        push_led(3117, 4'b1011);
        push_led(3121, 4'b0100);
`else
        push_led(0,    4'b0000);
        push_led(4,    4'b0000);
        push_led(5,    4'b0001);
        push_led(40,   4'b0001);
        push_led(41,   4'b0010);
        push_led(2397, 4'b0111);
        push_led(2401, 4'b1000);
        push_led(3017, 4'b1010);
        push_led(4797, 4'b1111);
        push_led(4801, 4'b0000);
        push_led(5757, 4'b0111);
        push_led(5760, 4'b0111);
        push_led(5761, 4'b0000);
`endif
        repeat (3) @(negedge clk);
        rst_t = 1'b0;
        for (int i = 0; i < 7000 && led_q.size() > 0; i++) @(negedge clk);
        check("led_queue_left", led_q.size(), 0);
        done_t = 1'b1;
    end

    int n_t = 0;
    initial begin : mon_t
        led_exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_t) n_t = 0;
            else       n_t++;
            if (led_q.size() > 0 && led_q[0].n == n_t) begin
                e = led_q.pop_front();
                $display("leds at edge %0d: %b", n_t, {t_led1, t_led2, t_led3, t_led4});
                check($sformatf("leds_n%0d", n_t), {t_led1, t_led2, t_led3, t_led4}, e.leds);
            end
        end
    end

    // Frame stimulus: frame 1 snapshots 00:01, frame 2 (00:17) is cut by reset at bit 100,
    // frame 3 after re-release snapshots 00:01 again.
    initial begin : stim_f
        push_frame(MASK_0001);
        push_frame(MASK_0017);
        push_frame(MASK_0001);
        repeat (3) @(negedge clk);
        rst_f = 1'b0;
        repeat (8461) @(negedge clk);
        rst_f = 1'b1;
        repeat (3) @(negedge clk);
        rst_f = 1'b0;
        for (int i = 0; i < 8000 && frames_done < 2; i++) @(negedge clk);
        check("frames_done", frames_done, 2);
        check("pix_queue_left", pix_q.size(), 0);
        check("gap_queue_left", gap_q.size(), 0);
        done_f = 1'b1;
    end

    int          mode = 0;  // 0: gap, 1: inside a frame
    int          low_run = 0;
    int          hi = 0;
    int          lo = 0;
    int          bit_cnt = 0;
    int          pix_cnt = 0;
    logic [23:0] sh = '0;

    initial begin : mon_f
        logic [23:0] exp_pix;
        forever begin
            @(posedge clk);
            #1;
            if (rst_f) begin
                check("ws_in_reset", f_ws, 1'b0);
                check("leds_in_reset", {f_led1, f_led2, f_led3, f_led4}, RST_LEDS);
                if (mode == 1)
                    repeat (16 - pix_cnt) if (pix_q.size() > 0) void'(pix_q.pop_front());
                mode = 0; low_run = 0; hi = 0; lo = 0; bit_cnt = 0; pix_cnt = 0;
            end else if (mode == 0) begin
                if (!f_ws) begin
                    low_run++;
                end else begin
                    if (gap_q.size() == 0) check("gap_unexpected", low_run, 0);
                    else                   check("gap_len", low_run, gap_q.pop_front());
                    mode = 1; hi = 1; lo = 0; bit_cnt = 0; pix_cnt = 0;
                end
            end else begin
                if (f_ws) begin
                    if (lo != 0) begin
                        check("bit_period", hi + lo, 15);
                        hi = 1; lo = 0;
                    end else begin
                        hi++;
                    end
                end else begin
                    if (hi == 0) check("bit_start", 0, 1);
                    else         lo++;
                end
                if (hi + lo == 15) begin
                    check("bit_high", (hi == 4 || hi == 8), 1);
                    sh = {sh[22:0], (hi >= 6)};
                    bit_cnt++;
                    hi = 0; lo = 0;
                    if (bit_cnt % 24 == 0) begin
                        exp_pix = (pix_q.size() > 0) ? pix_q.pop_front() : 24'hxxxxxx;
                        $display("frame %0d pixel %0d: %06h", frames_done, pix_cnt, sh);
                        check($sformatf("pixel%0d", pix_cnt), sh, exp_pix);
                        pix_cnt++;
                    end
                    if (bit_cnt == 384) begin
                        mode = 0; low_run = 0;
                        frames_done++;
                    end
                end
            end
        end
    end

    initial begin : finish_blk
        int i;
        for (i = 0; i < 30000 && !(done_t && done_f); i++) @(negedge clk);
        if (!(done_t && done_f)) check("global_timeout", 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/binary_clock_top.md
Name: binary_clock_top

Overview:
- Top level of a wooden binary clock: keeps 24-hour time (HH:MM) from the board clock.
- Shows the four BCD digits h1, h0, m1, m0 as a 4x4 WS2812 pixel matrix on a single serial data line.
- The least-significant bit of each digit is also mirrored on four discrete LEDs.
- Contains the prescaler, the BCD time counter and the WS2812 serializer; nothing sits downstream except the pixels.

Parameters:
- CLK_HZ, 12000000: clk cycles per one-second tick; must be ≥1.
- SEC_PER_MIN, 60: seconds per minute; must be ≥1; reduced for simulation.
- T0H_CYC, 4: high time of a WS2812 '0' bit, in clk cycles.
- T1H_CYC, 8: high time of a WS2812 '1' bit, in clk cycles; must be < TBIT_CYC.
- TBIT_CYC, 15: total WS2812 bit period, in clk cycles.
- TRST_CYC, 600: low latch/reset gap between frames, in clk cycles.
- ON_COLOR, 24'h001000: GRB colour of a lit pixel; unlit pixels send 24'h000000.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- led1  out  1  bit0 of h1 (tens of hours)
- led2  out  1  bit0 of h0 (units of hours)
- led3  out  1  bit0 of m1 (tens of minutes)
- led4  out  1  bit0 of m0 (units of minutes)
- ws_data  out  1  WS2812 serial data, idle low

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high, sampled on the rising clk edge.
  - While rst=1: prescaler=0, sec=0, h1=h0=m1=m0=0, led1..4=0, ws_data=0, serializer held at the start of the reset gap.
- Prescaler:
  - Counts 0..CLK_HZ-1.
  - sec_tick is a 1-cycle pulse when the count wraps.
  - First tick occurs CLK_HZ cycles after reset release.
- Seconds:
  - On sec_tick, sec increments 0..SEC_PER_MIN-1.
  - When sec wraps, min_tick pulses in the same cycle.
- Minutes, on min_tick:
  - m0 increments 0..9; on 9→0, m1 increments 0..5.
  - On 59→00, the hour increments.
- Hours (24-hour):
  - h0 0..9 while h1<2; h0 0..3 when h1=2.
  - 23:59 → 00:00.
  - All digit updates are registered in the same cycle as min_tick.
- LEDs: registered copies of digit bit0; update one cycle after the digit changes.
- Serializer, state IDLE_GAP:
  - ws_data=0 for TRST_CYC cycles.
  - Then snapshot the {h1,h0,m1,m0} digits into a frame register and enter SEND.
- Serializer, state SEND:
  - 16 pixels, 24 bits each (384 bits), MSB first, GRB order.
  - Pixel index p = col*4 + row; col 0=h1, 1=h0, 2=m1, 3=m0; row r = digit bit r.
  - Pixel colour = ON_COLOR if the digit bit is set, else 0.
  - Each bit: ws_data=1 for T1H_CYC ('1') or T0H_CYC ('0') cycles, then 0 until TBIT_CYC cycles have elapsed.
  - After bit 383 completes, return to IDLE_GAP. Frames repeat continuously.
- Snapshot rule: digit changes during SEND do not affect the frame in flight; they appear in the next frame.
- Reset mid-frame: ws_data goes low on the next edge; the serializer restarts with a full TRST_CYC gap after release.
- Unused digit bits (h1 bits 2-3, m1 bit 3) are always 0, so those pixels are always off.

Optional Feature:
- Macro: TWELVE_HOUR_EN.
- When defined:
  - Hours run 12-hour style, 12:59 → 01:00.
  - 09:59 → 10:00, 11:59 → 12:00.
  - Reset value is 12:00 (h1=1, h0=2, so led1=1, led2=0).
- When undefined: 24-hour behaviour as above, reset value 00:00.

Test Plan:
- Reset: hold rst=1 for 3 cycles, then release → led1..4=0; ws_data=0 for exactly 600 cycles, then first rising edge.
- Minute count (CLK_HZ=2, SEC_PER_MIN=2) → first min_tick 4 cycles after reset release; m0=1, led4=1 one cycle later.
- Minute carry 09→10 → m0=0, m1=1; led3=1, led4=0.
- Hour rollover, preload 23:59 then one min_tick → 00:00; led1..4=0. With TWELVE_HOUR_EN, 12:59 → 01:00, led2=1.
- Frame decode at 00:01 → 384 bits, each 15 cycles wide, high 4 or 8 cycles; only pixel 12 equals 24'h001000, all others zero; then 600 low cycles.
- Reset mid-SEND (assert at bit 100) → ws_data=0 on the next cycle; time returns to 00:00; after release, a full 600-cycle gap precedes a fresh frame.
